uart_rx_frame: RTL
==================

# uart_rx_frame

Byte-framing UART receive stage downstream of the falling-edge trigger. Takes the synchronized serial line plus the one-cycle start pulse the falling-edge trigger produces on each high-to-low transition. Samples the start, data, optional parity and stop bits at bit centres. Delivers each byte with a one-cycle strobe, or an error strobe for a bad frame.

## Interface
- CLKS_PER_BIT, 104: clock cycles per serial bit; legal range ≥ 4. H = CLKS_PER_BIT/2 (integer division) is the half-bit offset.
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  serial line, already synchronized to clk; idle level 1.
- start_pulse  in  1  one-cycle pulse from the falling-edge trigger, high in the cycle after rx fell.
- data  out  8  last received byte, LSB first on the wire; holds its value until the next frame completes.
- valid  out  1  one-cycle strobe: data holds a good frame.
- frame_err  out  1  one-cycle strobe: bad start, stop or parity.
- parity_err  out  1  one-cycle strobe, coincident with frame_err, when the parity bit mismatched.

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- Bit counter width is $clog2(CLKS_PER_BIT); bit index is 3 bits; shift register is 8 bits, shifting right with the new bit entering at bit 7.
- IDLE: on start_pulse = 1, clear the counter and enter START. Without start_pulse, remain in IDLE.
- START: at counter = H−1, sample rx.
  - rx = 0: clear the counter and enter DATA.
  - rx = 1 (glitch): return to IDLE with no strobe.
- DATA: sample rx each time counter = CLKS_PER_BIT−1, then clear the counter. After the 8th sample, enter PARITY (macro defined) or STOP.
- PARITY: sample after CLKS_PER_BIT cycles and compare against the even parity of the 8 data bits. Enter STOP.
- STOP: sample after CLKS_PER_BIT cycles, load data from the shift register and return to IDLE.
  - Stop = 1 and parity ok: valid = 1.
  - Otherwise: frame_err = 1; parity_err = 1 if the parity mismatched.
- start_pulse is ignored in every state except IDLE.
- A start_pulse arriving in the same cycle the STOP sample returns the FSM to IDLE is ignored.
- Stop bit = 0 (break): frame_err pulses, FSM enters IDLE. The next frame needs a fresh start_pulse.

## Timing
- Reference edge k is the clk edge at which start_pulse = 1 is registered in IDLE.
- Sample edges:
  - Start bit: k+H.
  - Data bit i (i = 0..7): k+H+(i+1)·CLKS_PER_BIT.
  - Parity: k+H+9·CLKS_PER_BIT.
  - Stop: k+H+9·CLKS_PER_BIT without parity, k+H+10·CLKS_PER_BIT with parity.
- Strobes (valid, frame_err, parity_err) and the data update are registered at the stop-sample edge. They are high for exactly the one following cycle.
- Throughput: back-to-back frames with zero idle bits are accepted, since the FSM is in IDLE one cycle after the stop-sample edge.
- Reset values: data = 8'h00, valid = 0, frame_err = 0, parity_err = 0, state = IDLE.
- rst asserted mid-frame takes effect at the next edge. The partial byte is discarded, no strobe is issued, and any start_pulse in the reset cycle is ignored.

## Configuration
- UART_RX_PARITY_EN defined: frame is 1 start, 8 data, 1 even-parity, 1 stop bit. The PARITY state exists; parity_err is live.
- UART_RX_PARITY_EN undefined: frame is 1 start, 8 data, 1 stop bit. The PARITY state is absent; parity_err is tied to 0.

## Test plan
- Bench uses CLKS_PER_BIT = 8 (H = 4) throughout.
- No parity, byte 0xA5 at line rate, start_pulse at edge k → data = 8'hA5, valid high only for the cycle after edge k+76; frame_err = 0.
- 1-cycle rx low glitch producing start_pulse, rx high at k+4 → FSM back in IDLE, no strobe, data unchanged.
- Byte 0x3C sent with stop bit = 0 → frame_err pulse after edge k+76, valid = 0, data = 8'h3C.
- Parity enabled: 0x81 with parity 0 → valid after edge k+84. Same byte with parity 1 → frame_err and parity_err pulse together after edge k+84.
- rst asserted for 1 cycle at k+40, then a clean frame 0x5A → no strobe for the aborted frame; the clean frame yields data = 8'h5A with valid.
- Two back-to-back frames 0x01 then 0xFE with no idle gap → two valid pulses, 80 cycles apart (no parity).

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: byte-framing UART receiver sampling start/data/parity/stop at bit centres.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       start_pulse,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_err_q;
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        idx   <= '0;
                        // a high line at mid-start means the edge was a glitch
                        state <= rx ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shreg <= {rx, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        par_bad <= rx != ^shreg;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        data  <= shreg;
                        state <= IDLE;
`ifdef UART_RX_PARITY_EN
                        if (rx && !par_bad) begin
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            par_err_q <= par_bad;
                        end
`else
                        if (rx) begin
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
